// File: rtl/mux8_serializer.sv
// mux8_serializer
// Sequencing stage for an external combinational 8:1 bit-select mux. Accepts a
// parallel byte over a valid/ready handshake, holds it on the mux data bus,
// walks the mux select through all eight positions and registers each returned
// bit onto a valid/ready serial output, followed by an optional idle gap.
//
// Parameters:
//   MSB_FIRST : 0 -> select order 0..7, 1 -> select order 7..0
//   GAP       : idle cycles after each frame before in_ready reasserts (0..15)
//
// Ports:
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_data      : parallel byte offer
//   in_ready              : high while idle (combinational from state)
//   mux_i, mux_sel        : registered data bus and select to the external mux
//   mux_y                 : combinational mux output returned to this block
//   ser_valid/ser_bit     : serial bit output, ser_last marks bit 8 of a frame
//   ser_ready             : downstream accepts the serial bit
//   frame_cnt             : completed frame count, wraps at 8 bits
module mux8_serializer #(
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned GAP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] mux_i,
  output logic [2:0] mux_sel,
  input  logic       mux_y,
  output logic       ser_valid,
  output logic       ser_bit,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [2:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] gap_cnt;

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mux_i     <= '0;
      mux_sel   <= SEL_START;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_last  <= 1'b0;
      frame_cnt <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mux_i   <= in_data;
            mux_sel <= SEL_START;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The output register is free when empty or being consumed this edge.
          if (!ser_valid || ser_ready) begin
            ser_bit   <= mux_y;
            ser_valid <= 1'b1;
            ser_last  <= (bit_cnt == 3'd7);
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_DRAIN;
            end else if (MSB_FIRST != 0) begin
              mux_sel <= mux_sel - 3'd1;
            end else begin
              mux_sel <= mux_sel + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (ser_ready) begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            gap_cnt   <= '0;
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// Testbench for mux8_serializer. Three instances share clock and reset:
// index 0 = defaults, 1 = MSB_FIRST, 2 = GAP of 3. Each drives its own
// behavioural 8:1 mux. Expected bit order, frame counts and busy lengths come
// from a byte-level reference model.
module tb_mux8_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] in_valid, in_ready, ser_valid, ser_bit, ser_last, ser_ready, mux_y;
  logic [7:0] in_data   [3];
  logic [7:0] mux_i     [3];
  logic [7:0] frame_cnt [3];
  logic [2:0] mux_sel   [3];

  int errors = 0;
  int checks = 0;
  int exp_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux8_serializer #(
      .MSB_FIRST((g == 1) ? 1 : 0),
      .GAP      ((g == 2) ? 3 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .mux_i    (mux_i[g]),
      .mux_sel  (mux_sel[g]),
      .mux_y    (mux_y[g]),
      .ser_valid(ser_valid[g]),
      .ser_bit  (ser_bit[g]),
      .ser_last (ser_last[g]),
      .ser_ready(ser_ready[g]),
      .frame_cnt(frame_cnt[g])
    );
    assign mux_y[g] = mux_i[g][mux_sel[g]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 2) ? 3 : 0;
  endfunction

  // Serial order as an 8-bit word: element k is the k-th bit on the wire.
  function automatic logic [7:0] ref_bits(input int d, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (d == 1) ? b[7-i] : b[i];
    return r;
  endfunction

  function automatic logic [2:0] sel_at(input int d, input int k);
    return (d == 1) ? 3'(7 - k) : 3'(k);
  endfunction

  // Sends one byte to instance d and follows the frame until in_ready returns.
  // Called and returns #1 after a rising edge.
  task automatic run_frame(input int d, input logic [7:0] b, input bit bp, input bit hold);
    logic [7:0] got;
    int n, busy, cyc, k;
    bit stalled;
    logic held_bit, held_last;
    got = '0; n = 0; busy = 0; cyc = 0; stalled = 0; held_bit = 0; held_last = 0;
    in_data[d]  = b;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("accept_wait", 32'(in_ready[d]), 1);
    @(posedge clk); #1;
    if (!hold) in_valid[d] = 1'b0;
    check("mux_i", 32'(mux_i[d]), 32'(b));
    cyc = 0;
    while (!in_ready[d] && cyc < 300) begin
      busy++;
      if (hold) in_data[d] = 8'($urandom);
      ser_ready[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_valid", 32'(ser_valid[d]), 1);
        check("stall_bit", 32'(ser_bit[d]), 32'(held_bit));
        check("stall_last", 32'(ser_last[d]), 32'(held_last));
      end
      if (!bp && busy <= 9) begin
        check("valid_win", 32'(ser_valid[d]), 32'(busy >= 2));
        k = (busy <= 8) ? busy - 1 : 7;
        check("sel", 32'(mux_sel[d]), 32'(sel_at(d, k)));
      end
      if (ser_valid[d] && ser_ready[d]) begin
        check("last", 32'(ser_last[d]), 32'(n == 7));
        if (n < 8) got[n] = ser_bit[d];
        n++;
      end
      stalled   = ser_valid[d] && !ser_ready[d];
      held_bit  = ser_bit[d];
      held_last = ser_last[d];
      @(posedge clk); #1; cyc++;
    end
    ser_ready[d] = 1'b1;
    exp_cnt[d] = (exp_cnt[d] + 1) % 256;
    check("frame_end", 32'(in_ready[d]), 1);
    check("nbits", 32'(n), 8);
    check("bits", 32'(got), 32'(ref_bits(d, b)));
    check("frame_cnt", 32'(frame_cnt[d]), 32'(exp_cnt[d]));
    if (!bp) check("busy", 32'(busy), 32'(9 + gap_of(d)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, seen;
    in_valid  = '0;
    ser_ready = '1;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0;
      exp_cnt[d] = 0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 1);
      check("rst_ser_valid", 32'(ser_valid[d]), 0);
      check("rst_ser_last", 32'(ser_last[d]), 0);
      check("rst_mux_sel", 32'(mux_sel[d]), (d == 1) ? 7 : 0);
      check("rst_frame_cnt", 32'(frame_cnt[d]), 0);
      check("rst_mux_i", 32'(mux_i[d]), 0);
    end

    run_frame(0, 8'hA5, 1'b0, 1'b0);
    run_frame(1, 8'h81, 1'b0, 1'b0);
    run_frame(1, 8'h01, 1'b0, 1'b0);
    check("mux_i_hold", 32'(mux_i[1]), 32'h01);

    run_frame(0, 8'h3C, 1'b1, 1'b0);
    repeat (4) run_frame(0, 8'($urandom), 1'b1, 1'b0);
    repeat (4) run_frame(1, 8'($urandom), 1'b1, 1'b0);
    repeat (2) run_frame(2, 8'($urandom), 1'b1, 1'b0);

    // Reset in the middle of a 0xFF frame on instance 0.
    in_data[0]  = 8'hFF;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 20) begin
      if (ser_valid[0] && ser_ready[0]) n++;
      @(posedge clk); #1; cyc++;
    end
    check("mid_bits_seen", 32'(n), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready[0]), 1);
    check("arst_ser_valid", 32'(ser_valid[0]), 0);
    check("arst_ser_bit", 32'(ser_bit[0]), 0);
    check("arst_ser_last", 32'(ser_last[0]), 0);
    check("arst_mux_i", 32'(mux_i[0]), 0);
    check("arst_mux_sel", 32'(mux_sel[0]), 0);
    check("arst_frame_cnt", 32'(frame_cnt[0]), 0);
    for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      if (ser_valid != 3'b000) seen++;
      @(posedge clk); #1;
    end
    check("post_rst_no_valid", 32'(seen), 0);
    run_frame(0, 8'h0F, 1'b0, 1'b0);

    // 256 back-to-back frames with in_valid held high on the GAP instance.
    for (int f = 0; f < 256; f++) run_frame(2, 8'($urandom), 1'b0, 1'b1);
    in_valid[2] = 1'b0;
    check("wrap_frame_cnt", 32'(frame_cnt[2]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
